// File: rtl/u712_local_bus_initiator_if.sv
// Local bus and internal request signals for the U712 local bus initiator.
// The master modport is the initiator's view; slave is the requester/arbiter/responder side.
interface u712_local_bus_initiator_if;
    logic        REQ;
    logic        REQ_RnW;
    logic [31:0] REQ_ADDR;
    logic [1:0]  REQ_SIZ;
    logic [31:0] REQ_WDATA;
    logic        ACK;
    logic        ERR;
    logic        BURST_INH;
    logic [31:0] RDATA;
    logic        RBEAT;
    logic        WBEAT;

    logic        BRn;
    logic        BGn;
    logic        BBn;
    logic        TSn;
    logic        TIPn;
    logic        RnW;
    logic [31:0] A;
    logic [1:0]  SIZ;
    logic [31:0] D_OUT;
    logic        D_OE;
    logic [31:0] D_IN;
    logic        TACKn;
    logic        TEAn;
    logic        TBIn;
    logic        TCIn;

    modport master (
        input  REQ, REQ_RnW, REQ_ADDR, REQ_SIZ, REQ_WDATA,
        input  BGn, D_IN, TACKn, TEAn, TBIn, TCIn,
        output ACK, ERR, BURST_INH, RDATA, RBEAT, WBEAT,
        output BRn, BBn, TSn, TIPn, RnW, A, SIZ, D_OUT, D_OE
    );

    modport slave (
        output REQ, REQ_RnW, REQ_ADDR, REQ_SIZ, REQ_WDATA,
        output BGn, D_IN, TACKn, TEAn, TBIn, TCIn,
        input  ACK, ERR, BURST_INH, RDATA, RBEAT, WBEAT,
        input  BRn, BBn, TSn, TIPn, RnW, A, SIZ, D_OUT, D_OE
    );
endinterface

// File: rtl/u712_local_bus_initiator.sv
// 68040-style local bus master: arbitrates, issues TSn/TIPn transfers (single or 4-beat line),
// decodes TACKn/TEAn/TBIn termination, with bounded retry and a no-termination timeout.
module u712_local_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic CLK40,
    input  logic RESET,
    u712_local_bus_initiator_if.master bus
);
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_WAIT, S_DONE} state_t;

    state_t          state;
    logic [1:0]      beat;
    logic [TO_W-1:0] to_cnt;
    logic [RT_W-1:0] retry_cnt;

    logic beat_ok, retry_hit, bus_err, no_term;
    logic is_line, tbi_stop, last_beat, end_ok, end_err;
    logic unused_tci;

    // TCIn carries no behaviour of its own in this master
    assign unused_tci = bus.TCIn;

    always_comb begin
        beat_ok   = !bus.TACKn &&  bus.TEAn;
        retry_hit = !bus.TACKn && !bus.TEAn;
        bus_err   =  bus.TACKn && !bus.TEAn;
        no_term   =  bus.TACKn &&  bus.TEAn;
        is_line   = (bus.SIZ == 2'b11);
        tbi_stop  = is_line && (beat == 2'd0) && !bus.TBIn;
        last_beat = !is_line || tbi_stop || (beat == 2'd3);
        end_ok    = (state == S_WAIT) && beat_ok && last_beat;
        end_err   = (state == S_WAIT) &&
                    ((retry_hit && (retry_cnt >= RT_W'(MAX_RETRY))) || bus_err ||
                     (no_term && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))));
    end

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            beat          <= '0;
            to_cnt        <= '0;
            retry_cnt     <= '0;
            bus.BRn       <= 1'b1;
            bus.BBn       <= 1'b1;
            bus.TSn       <= 1'b1;
            bus.TIPn      <= 1'b1;
            bus.RnW       <= 1'b1;
            bus.A         <= '0;
            bus.SIZ       <= '0;
            bus.D_OUT     <= '0;
            bus.D_OE      <= 1'b0;
            bus.ACK       <= 1'b0;
            bus.ERR       <= 1'b0;
            bus.RBEAT     <= 1'b0;
            bus.WBEAT     <= 1'b0;
            bus.BURST_INH <= 1'b0;
            bus.RDATA     <= '0;
        end else begin
            bus.ACK       <= 1'b0;
            bus.ERR       <= 1'b0;
            bus.RBEAT     <= 1'b0;
            bus.WBEAT     <= 1'b0;
            bus.BURST_INH <= 1'b0;
            // requester advances REQ_WDATA in the WBEAT cycle; pick it up one clock later
            if (bus.WBEAT) bus.D_OUT <= bus.REQ_WDATA;

            case (state)
                S_IDLE: begin
                    retry_cnt <= '0;
                    if (bus.REQ) begin
                        bus.RnW <= bus.REQ_RnW;
                        bus.A   <= bus.REQ_ADDR;
                        bus.SIZ <= bus.REQ_SIZ;
                        bus.BRn <= 1'b0;
                        state   <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (!bus.BGn) begin
                        bus.BRn  <= 1'b1;
                        bus.BBn  <= 1'b0;
                        bus.TSn  <= 1'b0;
                        bus.TIPn <= 1'b0;
                        bus.D_OE <= !bus.RnW;
                        if (!bus.RnW) bus.D_OUT <= bus.REQ_WDATA;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    bus.TSn <= 1'b1;
                    beat    <= '0;
                    to_cnt  <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (beat_ok) begin
                        if (bus.RnW) begin
                            bus.RBEAT <= 1'b1;
                            bus.RDATA <= bus.D_IN;
                        end else begin
                            bus.WBEAT <= 1'b1;
                        end
                        if (!last_beat) beat <= beat + 2'd1;
                    end
                    if (retry_hit && !end_err) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        bus.TSn   <= 1'b0;
                        state     <= S_START;
                    end
                    if (no_term && !end_err && (to_cnt != '1)) to_cnt <= to_cnt + 1'b1;
                    if (end_ok || end_err) begin
                        bus.ACK       <= end_ok;
                        bus.ERR       <= end_err;
                        bus.BURST_INH <= end_ok && tbi_stop;
                        bus.TIPn      <= 1'b1;
                        bus.BBn       <= 1'b1;
                        bus.D_OE      <= 1'b0;
                        state         <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_u712_local_bus_initiator.sv
// Directed bench for u712_local_bus_initiator: a small scripted slave answers each WAIT cycle
// from a response queue; expected values are hand-derived per transfer.
module tb_u712_local_bus_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    u712_local_bus_initiator_if bus();

    u712_local_bus_initiator #(
        .TIMEOUT_CYCLES(255),
        .MAX_RETRY(3)
    ) dut (
        .CLK40(clk),
        .RESET(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // response codes: 0 none, 1 TACK, 2 TACK+TBI, 3 TACK+TEA (retry), 4 TEA
    int          resp[$];
    logic [31:0] wdata[4];
    logic [31:0] rd_base;
    int          gnt_delay;
    int          ts_cnt, wbeat_cnt, ack_cnt, err_cnt, a_bad, first_ts, end_cyc, beat_i;
    logic        binh, doe_end, tipn_after, bbn_after, pulse_after, brn0, done;
    logic [31:0] rdata_q[$];
    logic [31:0] dcap_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input logic rnw, input logic [31:0] addr, input logic [1:0] siz,
                            input int limit);
        int code;
        ts_cnt = 0; wbeat_cnt = 0; ack_cnt = 0; err_cnt = 0; a_bad = 0;
        first_ts = -1; end_cyc = -1; beat_i = 0; binh = 1'b0; doe_end = 1'b1; done = 1'b0;
        rdata_q.delete();
        dcap_q.delete();
        bus.REQ = 1'b1; bus.REQ_RnW = rnw; bus.REQ_ADDR = addr; bus.REQ_SIZ = siz;
        bus.REQ_WDATA = wdata[0];
        bus.BGn = (gnt_delay > 0);
        for (int cyc = 0; cyc < limit && !done; cyc++) begin
            @(negedge clk);
            bus.TACKn = 1'b1; bus.TEAn = 1'b1; bus.TBIn = 1'b1;
            bus.BGn = (cyc < gnt_delay);
            if (cyc == 0) brn0 = bus.BRn;
            if (!bus.TSn) begin
                ts_cnt++;
                if (first_ts < 0) first_ts = cyc;
            end
            if (bus.A !== addr || bus.SIZ !== siz) a_bad++;
            if (bus.RBEAT) rdata_q.push_back(bus.RDATA);
            if (bus.WBEAT) begin
                wbeat_cnt++;
                if (wbeat_cnt < 4) bus.REQ_WDATA = wdata[wbeat_cnt];
            end
            if (bus.ACK) ack_cnt++;
            if (bus.ERR) err_cnt++;
            if (bus.ACK || bus.ERR) begin
                done = 1'b1; end_cyc = cyc; binh = bus.BURST_INH; doe_end = bus.D_OE;
                bus.REQ = 1'b0;
            end else if (!bus.TIPn && bus.TSn) begin
                code = (resp.size() > 0) ? resp.pop_front() : 0;
                if (code == 1 || code == 2) begin
                    bus.TACKn = 1'b0;
                    bus.TBIn  = (code != 2);
                    bus.D_IN  = rd_base + 32'(beat_i);
                    if (!rnw) dcap_q.push_back(bus.D_OUT);
                    beat_i++;
                end else if (code == 3) begin
                    bus.TACKn = 1'b0; bus.TEAn = 1'b0;
                end else if (code == 4) begin
                    bus.TEAn = 1'b0;
                end
            end
        end
        if (!done) begin
            chk("xfer_bound", 32'd0, 32'd1);
            bus.REQ = 1'b0;
        end
        @(negedge clk);
        tipn_after  = bus.TIPn;
        bbn_after   = bus.BBn;
        pulse_after = bus.ACK | bus.ERR | bus.RBEAT | bus.WBEAT;
    endtask

    initial begin
        int found;
        int pulses;
        bus.REQ = 1'b0; bus.REQ_RnW = 1'b1; bus.REQ_ADDR = '0; bus.REQ_SIZ = '0;
        bus.REQ_WDATA = '0; bus.BGn = 1'b1; bus.D_IN = '0;
        bus.TACKn = 1'b1; bus.TEAn = 1'b1; bus.TBIn = 1'b1; bus.TCIn = 1'b1;
        gnt_delay = 0; rd_base = '0;
        wdata[0] = '0; wdata[1] = '0; wdata[2] = '0; wdata[3] = '0;

        repeat (2) @(negedge clk);
        chk("rst_brn",  bus.BRn, 1);   chk("rst_bbn",  bus.BBn, 1);
        chk("rst_tsn",  bus.TSn, 1);   chk("rst_tipn", bus.TIPn, 1);
        chk("rst_rnw",  bus.RnW, 1);   chk("rst_doe",  bus.D_OE, 0);
        chk("rst_a",    bus.A, 0);     chk("rst_dout", bus.D_OUT, 0);
        chk("rst_pulses", {bus.ACK, bus.ERR, bus.RBEAT, bus.WBEAT, bus.BURST_INH}, 0);
        rst = 1'b0;
        @(negedge clk);

        // long read, immediate grant, TACK in the clock after TSn
        rd_base = 32'hCAFE_0000; resp = {1};
        run_xfer(1'b1, 32'h00DF_F004, 2'b00, 20);
        chk("lr_brn0", brn0, 0);       chk("lr_ts", ts_cnt, 1);
        chk("lr_first_ts", first_ts, 1);
        chk("lr_ack_cyc", end_cyc, 3); chk("lr_ack", ack_cnt, 1);
        chk("lr_err", err_cnt, 0);     chk("lr_nbeat", rdata_q.size(), 1);
        chk("lr_rdata", rdata_q[0], 32'hCAFE_0000);
        chk("lr_a", a_bad, 0);         chk("lr_binh", binh, 0);
        chk("lr_bbn_after", bbn_after, 1); chk("lr_pulse_after", pulse_after, 0);

        // line write, TACK every other WAIT cycle
        wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
        wdata[2] = 32'h3333_3333; wdata[3] = 32'h4444_4444;
        resp = {1, 0, 1, 0, 1, 0, 1};
        run_xfer(1'b0, 32'h0000_0010, 2'b11, 40);
        chk("lw_wbeats", wbeat_cnt, 4); chk("lw_ts", ts_cnt, 1);
        chk("lw_ack", ack_cnt, 1);      chk("lw_binh", binh, 0);
        chk("lw_a_siz", a_bad, 0);      chk("lw_doe_end", doe_end, 0);
        chk("lw_ncap", dcap_q.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("lw_dout%0d", k), dcap_q[k], wdata[k]);

        // line read burst-inhibited on first beat
        rd_base = 32'h2000_0000; resp = {2};
        run_xfer(1'b1, 32'h0000_0100, 2'b11, 20);
        chk("lbi_nbeat", rdata_q.size(), 1); chk("lbi_ack", ack_cnt, 1);
        chk("lbi_binh", binh, 1);            chk("lbi_tipn_after", tipn_after, 1);

        // full line read; TBI on beat 2 must be ignored
        rd_base = 32'h3000_0000; resp = {1, 2, 1, 1};
        run_xfer(1'b1, 32'h0000_0200, 2'b11, 20);
        chk("lrd_nbeat", rdata_q.size(), 4); chk("lrd_binh", binh, 0);
        chk("lrd_d1", rdata_q[1], 32'h3000_0001); chk("lrd_d3", rdata_q[3], 32'h3000_0003);

        // TBI on a non-line transfer is ignored
        rd_base = 32'h4000_0000; resp = {2};
        run_xfer(1'b1, 32'h0000_0300, 2'b10, 20);
        chk("wbi_ack", ack_cnt, 1); chk("wbi_binh", binh, 0);

        // two retries then success
        resp = {3, 3, 1};
        run_xfer(1'b1, 32'h0000_0400, 2'b00, 30);
        chk("rt2_ts", ts_cnt, 3); chk("rt2_ack", ack_cnt, 1); chk("rt2_err", err_cnt, 0);

        // retry limit, twice to show the retry count clears between requests
        for (int r = 0; r < 2; r++) begin
            resp = {3, 3, 3, 3};
            run_xfer(1'b1, 32'h0000_0500, 2'b00, 30);
            chk($sformatf("rtx%0d_ts", r), ts_cnt, 4);
            chk($sformatf("rtx%0d_err", r), err_cnt, 1);
            chk($sformatf("rtx%0d_ack", r), ack_cnt, 0);
        end

        // no termination: timeout
        resp = {};
        run_xfer(1'b1, 32'h0000_0600, 2'b00, 300);
        chk("to_err", err_cnt, 1); chk("to_ack", ack_cnt, 0);
        chk("to_len", end_cyc - first_ts, 256); chk("to_bbn_after", bbn_after, 1);

        // bus error
        resp = {4};
        run_xfer(1'b1, 32'h0000_0700, 2'b00, 20);
        chk("tea_err", err_cnt, 1); chk("tea_ack", ack_cnt, 0);
        chk("tea_rbeat", rdata_q.size(), 0);

        // delayed grant
        gnt_delay = 4; rd_base = 32'h5000_0000; resp = {1};
        run_xfer(1'b1, 32'h0000_0800, 2'b00, 30);
        chk("gd_first_ts", first_ts, 5); chk("gd_ack_cyc", end_cyc, 7);
        chk("gd_ack", ack_cnt, 1);
        gnt_delay = 0;

        // reset while waiting for termination of a write
        bus.REQ = 1'b1; bus.REQ_RnW = 1'b0; bus.REQ_ADDR = 32'h40; bus.REQ_SIZ = 2'b00;
        bus.REQ_WDATA = 32'h5A5A_5A5A; bus.BGn = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (!bus.TIPn && bus.TSn) found = 1;
        end
        chk("rw_reach_wait", found, 1);
        chk("rw_doe_before", bus.D_OE, 1);
        #2 rst = 1'b1;
        #1;
        chk("rw_bbn", bus.BBn, 1);   chk("rw_tipn", bus.TIPn, 1);
        chk("rw_tsn", bus.TSn, 1);   chk("rw_doe", bus.D_OE, 0);
        chk("rw_brn", bus.BRn, 1);
        bus.REQ = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ACK || bus.ERR) pulses++;
        end
        chk("rw_no_pulse", pulses, 0);

        rd_base = 32'h6000_0000; resp = {1};
        run_xfer(1'b1, 32'h0000_0900, 2'b00, 20);
        chk("post_rst_ack", ack_cnt, 1);
        chk("post_rst_rdata", rdata_q.size() > 0 ? rdata_q[0] : 32'hDEAD_BEEF, 32'h6000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
